// File: rtl/dual_prio_pkg.sv
// Shared widths, codes and types for the 12-request dual priority encoder.
package dual_prio_pkg;

    localparam int NUM_REQ = 12;
    localparam int CODE_W  = 4;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [CODE_W-1:0]  prio_code_t;

    localparam prio_code_t CODE_NONE = 4'd0;

endpackage

// File: rtl/prio_enc12.sv
// Combinational 12-to-4 priority encoder: code = index of highest set bit + 1,
// or CODE_NONE when no bit is set.
module prio_enc12
    import dual_prio_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    output logic [CODE_W-1:0]  o_code
);

    // Scan from the lowest bit upward so the highest set bit wins.
    always_comb begin
        o_code = CODE_NONE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req[i]) begin
                o_code = prio_code_t'(i + 1);
            end
        end
    end

endmodule

// File: rtl/dual_priority_encoder.sv
// Registered dual priority encoder: highest and second-highest request codes.
// Define DUAL_PRIO_IN_REG_EN to register dual_in before encoding (2-cycle latency).
module dual_priority_encoder
    import dual_prio_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] dual_in,
    output logic [CODE_W-1:0]  prior_1,
    output logic [CODE_W-1:0]  prior_2
);

    req_vec_t   w_req;
    req_vec_t   w_mask;
    req_vec_t   w_req_rest;
    prio_code_t w_code_1;
    prio_code_t w_code_2;
    prio_code_t r_prior_1;
    prio_code_t r_prior_2;

`ifdef DUAL_PRIO_IN_REG_EN
    req_vec_t r_dual_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dual_in <= '0;
        end else begin
            r_dual_in <= dual_in;
        end
    end

    assign w_req = r_dual_in;
`else
    assign w_req = dual_in;
`endif

    prio_enc12 u_enc_first (
        .i_req  (w_req),
        .o_code (w_code_1)
    );

    // Decode the winning code back to a one-hot mask; CODE_NONE yields no bit.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign w_mask[gi] = (w_code_1 == prio_code_t'(gi + 1));
        end
    endgenerate

    assign w_req_rest = w_req & ~w_mask;

    prio_enc12 u_enc_second (
        .i_req  (w_req_rest),
        .o_code (w_code_2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prior_1 <= CODE_NONE;
            r_prior_2 <= CODE_NONE;
        end else begin
            r_prior_1 <= w_code_1;
            r_prior_2 <= w_code_2;
        end
    end

    assign prior_1 = r_prior_1;
    assign prior_2 = r_prior_2;

endmodule

// File: tb/tb_dual_priority_encoder.sv
// Scoreboard bench for dual_priority_encoder: directed, exhaustive and random inputs.
module tb_dual_priority_encoder;

`ifdef DUAL_PRIO_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [11:0] dual_in;
    logic [3:0]  prior_1;
    logic [3:0]  prior_2;

    typedef struct {
        logic [11:0] v;
        logic [3:0]  e1;
        logic [3:0]  e2;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   drv_done = 0;

    dual_priority_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dual_in (dual_in),
        .prior_1 (prior_1),
        .prior_2 (prior_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: scan requests in rising priority; each new hit demotes the old winner.
    function automatic void ref_model(input logic [11:0] v, output logic [3:0] e1, output logic [3:0] e2);
        int best   = 0;
        int second = 0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) begin
                second = best;
                best   = i + 1;
            end
        end
        e1 = 4'(best);
        e2 = 4'(second);
    endfunction

    task automatic check_now(input string name, input logic [3:0] e1, input logic [3:0] e2);
        n_checks++;
        if (prior_1 !== e1 || prior_2 !== e2) begin
            n_errors++;
            $display("FAIL %s: got prior_1=%0d prior_2=%0d, expected prior_1=%0d prior_2=%0d",
                     name, prior_1, prior_2, e1, e2);
        end else begin
            $display("ok   %s: prior_1=%0d prior_2=%0d", name, prior_1, prior_2);
        end
    endtask

    task automatic issue(input logic [11:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        dual_in = v;
        e.v = v;
        ref_model(v, e.e1, e.e2);
        e.due = cyc + LAT;
        sb_q.push_back(e);
    endtask

    // Monitor: compares whenever a queued transaction's output is due.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            if (sb_q[0].due < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_missed: in=%03h due=%0d now=%0d", sb_q[0].v, sb_q[0].due, cyc);
                void'(sb_q.pop_front());
            end else if (sb_q[0].due == cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                if (prior_1 !== e.e1 || prior_2 !== e.e2) begin
                    n_errors++;
                    $display("FAIL enc in=%03h: got (%0d,%0d) expected (%0d,%0d)",
                             e.v, prior_1, prior_2, e.e1, e.e2);
                end else begin
                    $display("txn in=%03h -> prior_1=%0d prior_2=%0d", e.v, prior_1, prior_2);
                end
                n_checks++;
                if ((prior_2 != 0 && prior_2 >= prior_1) || prior_1 > 4'd12 ||
                    (prior_1 == 0 && prior_2 != 0)) begin
                    n_errors++;
                    $display("FAIL invariant in=%03h: got (%0d,%0d) required prior_2<prior_1 or prior_2==0, codes<=12",
                             e.v, prior_1, prior_2);
                end
            end
        end
    end

    logic [11:0] directed [10];

    initial begin
        int wait_cyc;
        directed = '{12'b110000000000, 12'b010000000001, 12'b000000000011, 12'b000000000000,
                     12'b000010000000, 12'b000010000100, 12'h001, 12'h800, 12'hFFF, 12'h001};
        rst_n   = 1'b0;
        dual_in = '0;
        #2;
        check_now("reset_initial", 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        dual_in = 12'hFFF;
        repeat (3) @(posedge clk);
        #3;
        check_now("pre_reset_fff", 4'd12, 4'd11);
        rst_n = 1'b0;
        #1;
        check_now("async_reset_immediate", 4'd0, 4'd0);
        @(posedge clk);
        #1;
        check_now("reset_hold", 4'd0, 4'd0);
        rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        check_now("reset_release_fff", 4'd12, 4'd11);

        foreach (directed[i]) issue(directed[i]);
        for (int v = 0; v < 4096; v++) issue(12'(v));
        for (int k = 0; k < 200; k++) issue(12'($urandom_range(0, 4095)));
        drv_done = 1;

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d transactions left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
